y_muldiv: RTL
=============

Name: y_muldiv

Overview:
- Iterative multiply/divide unit; multi-cycle companion to the single-cycle ALU in the EX stage of the RISC-V datapath.
- Implements the eight RV32M operations over a WIDTH-bit datapath.
- Uses a start/ready/done handshake so the control unit can stall the pipeline while an operation is in flight.

Parameters:
- WIDTH, 32, operand/result width in bits; must be even and at least 4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when ready=1.
- op  input  3  operation, RV32M funct3 encoding (see Behaviour).
- a  input  WIDTH  operand 1: rs1 / multiplicand / dividend.
- b  input  WIDTH  operand 2: rs2 / multiplier / divisor.
- ready  output  1  high in IDLE; unit will accept start.
- done  output  1  one-cycle pulse; z and dz are valid from this cycle on.
- z  output  WIDTH  result; holds until the next done.
- dz  output  1  divide-by-zero flag for the last result; holds with z.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, ready=1, done=0, z=0, dz=0, iteration counter=0. An in-flight operation is discarded and no done is produced.
- op encoding:
  - 000 MUL: low half of the product.
  - 001 MULH: high half, signed×signed.
  - 010 MULHSU: high half, signed a × unsigned b.
  - 011 MULHU: high half, unsigned×unsigned.
  - 100 DIV: signed quotient.
  - 101 DIVU: unsigned quotient.
  - 110 REM: signed remainder.
  - 111 REMU: unsigned remainder.
- States: IDLE, CALC, FIX.
- IDLE, start=1 (accept edge):
  - Latch op and the operand magnitudes (absolute value for signed operands).
  - Record the result sign: product sign = sign(a) XOR sign(b); quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - Clear the counter.
  - Next state: CALC, or FIX directly for a special case.
- CALC: one radix-2 step per cycle, WIDTH cycles total.
  - Multiply: shift-add into a 2×WIDTH accumulator.
  - Divide: restoring shift-subtract (remainder register WIDTH+1 bits).
  - When the counter reaches WIDTH-1, next state is FIX.
- FIX: apply sign correction; select low half, high half, quotient or remainder; register into z and dz; pulse done=1 for the following cycle; next state IDLE.
- Latency: normal operation has done high in the cycle after the (WIDTH+2)th rising edge counted from the accept edge inclusive. For WIDTH=32, done is seen 34 edges after accept.
- Special cases, decided at accept; these skip CALC, so done is high after 2 edges:
  - Division with b=0: quotient = all ones, remainder = a, dz=1.
  - Signed overflow, a = most-negative and b = all ones (DIV/REM only): quotient = a, remainder = 0, dz=0.
- dz=0 for every other operation, including all multiplies.
- ready=0 from the accept edge until the edge that enters IDLE; ready and done are both high in the done cycle.
- A new start in the done cycle is accepted (back-to-back operation).
- start while ready=0 is ignored and is not queued.
- a, b and op are don't-care after the accept edge.
- z and dz change only on the FIX→IDLE edge or on reset.

Decomposition:
- Shared package holds:
  - op encodings OP_MUL..OP_REMU.
  - state encodings ST_IDLE, ST_CALC, ST_FIX.
  - special-case quotient constant (all ones).
- One combinational sub-module, y_md_step:
  - Inputs: accumulator/remainder, operand, mode.
  - Output: the next-iteration value (add-or-pass for multiply, subtract-and-restore for divide).
  - Keeps the FSM module focused on control and sign handling.

Test Plan (WIDTH=32):
- MUL a=7, b=0xFFFFFFFD (-3) → z=0xFFFFFFEB, dz=0; done exactly 34 edges after accept; ready low throughout.
- MULHU a=b=0xFFFFFFFF → z=0xFFFFFFFE; MULH a=b=0x80000000 → z=0x40000000; MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → z=0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 → z=0xFFFFFFFD; REM with the same operands → z=0xFFFFFFFF; DIVU a=100, b=7 → z=14; REMU → z=2.
- DIVU a=5, b=0 → z=0xFFFFFFFF, dz=1, done 2 edges after accept; REMU a=5, b=0 → z=5, dz=1; DIV a=0x80000000, b=0xFFFFFFFF → z=0x80000000, dz=0; REM with the same operands → z=0.
- Pulse start with new operands at edge 10 of a running MUL → ignored, first result unchanged. Raise start in the done cycle → second operation accepted, and its done follows 34 edges later.
- Assert reset asynchronously mid-CALC (edge 15) → ready=1, z=0, dz=0 immediately, no done pulse. A following start runs to a correct result.

Source files
------------

// File: rtl/y_muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
package y_muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // Replicated to WIDTH bits for the divide-by-zero quotient.
    localparam logic QUO_DZ_BIT = 1'b1;

    function automatic logic a_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV)  || (op == OP_REM);
    endfunction

    function automatic logic b_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/y_muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring
// shift-subtract for divide.
module y_md_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_opnd,
    input  logic               i_div,
    output logic [2*WIDTH-1:0] o_nxt
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_rem;

    always_comb begin
        w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]}
                + {1'b0, (i_acc[0] ? i_opnd : {WIDTH{1'b0}})};
        w_shift = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
        w_trial = w_shift - {1'b0, i_opnd};
        // A set top bit means the trial subtraction borrowed: restore.
        w_rem   = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
        o_nxt   = i_div ? {w_rem, i_acc[WIDTH-2:0], ~w_trial[WIDTH]}
                        : {w_sum, i_acc[WIDTH-1:1]};
    end

endmodule

// File: rtl/y_muldiv.sv
// Iterative RV32M multiply/divide unit with start/ready/done handshake.
module y_muldiv
    import y_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             dz
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             r_state;
    state_t             w_next;
    logic [CW-1:0]      r_cnt;
    logic [2:0]         r_op;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] w_step;
    logic [2*WIDTH-1:0] w_mres;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH-1:0]   w_q;
    logic [WIDTH-1:0]   w_r;
    logic [WIDTH-1:0]   w_res;
    logic [WIDTH-1:0]   r_z;
    logic               r_qneg;
    logic               r_rneg;
    logic               r_dzp;
    logic               r_dz;
    logic               r_done;
    logic               w_sa;
    logic               w_sb;
    logic               w_div0;
    logic               w_ovf;

    assign w_sa    = a_signed(op) & a[WIDTH-1];
    assign w_sb    = b_signed(op) & b[WIDTH-1];
    assign w_mag_a = w_sa ? -a : a;
    assign w_mag_b = w_sb ? -b : b;
    assign w_div0  = op[2] & (b == {WIDTH{1'b0}});
    assign w_ovf   = ((op == OP_DIV) || (op == OP_REM))
                   & (a == {1'b1, {(WIDTH-1){1'b0}}})
                   & (b == {WIDTH{1'b1}});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (start) w_next = (w_div0 | w_ovf) ? ST_FIX : ST_CALC;
            ST_CALC: if (r_cnt == LAST) w_next = ST_FIX;
            ST_FIX:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ready = (r_state == ST_IDLE);
        done  = r_done;
        z     = r_z;
        dz    = r_dz;
    end

    y_md_step #(.WIDTH(WIDTH)) u_step (
        .i_acc  (r_acc),
        .i_opnd (r_opnd),
        .i_div  (r_op[2]),
        .o_nxt  (w_step)
    );

    always_comb begin
        w_mres = r_qneg ? -r_acc : r_acc;
        w_q    = r_qneg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_r    = r_rneg ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        w_res  = w_q;
        unique case (r_op)
            OP_MUL:                     w_res = w_mres[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_res = w_mres[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:            w_res = w_q;
            OP_REM, OP_REMU:            w_res = w_r;
            default:                    w_res = w_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_op   <= '0;
            r_acc  <= '0;
            r_opnd <= '0;
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
            r_dzp  <= 1'b0;
            r_z    <= '0;
            r_dz   <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: if (start) begin
                    r_op   <= op;
                    r_cnt  <= '0;
                    r_dzp  <= w_div0;
                    r_opnd <= op[2] ? w_mag_b : w_mag_a;
                    r_qneg <= w_sa ^ w_sb;
                    r_rneg <= w_sa;
                    // Special cases preload the final quotient/remainder.
                    if (w_div0 | w_ovf) begin
                        r_qneg <= 1'b0;
                        r_rneg <= 1'b0;
                    end
                    if (w_div0)
                        r_acc <= {a, {WIDTH{QUO_DZ_BIT}}};
                    else if (w_ovf)
                        r_acc <= {{WIDTH{1'b0}}, a};
                    else if (op[2])
                        r_acc <= {{WIDTH{1'b0}}, w_mag_a};
                    else
                        r_acc <= {{WIDTH{1'b0}}, w_mag_b};
                end
                ST_CALC: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt + 1'b1;
                end
                ST_FIX: begin
                    r_z    <= w_res;
                    r_dz   <= r_dzp;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
